// File: rtl/hpdcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_pkg : shared types and default sizing for the HPDcache      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package hpdcache_pkg;

  localparam int PARAM_WBUF_DIR_ENTRIES   = 16;
  localparam int PARAM_WBUF_TIMECNT_WIDTH = 4;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OPEN = 2'd1,
    PEND = 2'd2,
    SENT = 2'd3
  } hpdcache_wbuf_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/hpdcache_rrarb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_rrarb : round-robin arbiter, pointer advances on handshake, |
// |                  offered index held stable while not accepted        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module hpdcache_rrarb #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int PW = IDX_W + 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic [PW-1:0]    pos;

  // First requester at or after the pointer, wrapping at N.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + PW'(k);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = pos[IDX_W-1:0];
      end
    end
  end

  // A held offer stays a requester until accepted, so valid needs no extra term.
  always_comb begin
    valid_o    = |req_i;
    idx_o      = hold_q ? hold_idx_q : sel_idx;
    hold_d     = valid_o & ~ready_i;
    hold_idx_d = idx_o;
    ptr_d      = ptr_q;
    if (valid_o && ready_i) begin
      ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_wbuf_flush_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_wbuf_flush_sched : write-buffer entry lifecycle, ageing and |
// |                             round-robin send scheduling              |
// | Revision                  : 1.0                                      |
// +----------------------------------------------------------------------+
module hpdcache_wbuf_flush_sched
  import hpdcache_pkg::*;
#(
  parameter  int N_ENTRIES     = PARAM_WBUF_DIR_ENTRIES,
  parameter  int TIMECNT_WIDTH = PARAM_WBUF_TIMECNT_WIDTH,
  localparam int IDX_W         = $clog2(N_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i,
  input  logic                     cfg_reset_timecnt_on_write_i,
  input  logic                     alloc_req_i,
  output logic                     alloc_gnt_o,
  output logic [IDX_W-1:0]         alloc_idx_o,
  input  logic                     write_i,
  input  logic [IDX_W-1:0]         write_idx_i,
  input  logic                     close_i,
  input  logic [IDX_W-1:0]         close_idx_i,
  input  logic                     flush_all_i,
  output logic                     send_valid_o,
  output logic [IDX_W-1:0]         send_idx_o,
  input  logic                     send_ready_i,
  input  logic                     ack_i,
  input  logic [IDX_W-1:0]         ack_idx_i,
  output logic                     empty_o,
  output logic                     full_o
);

  hpdcache_wbuf_sched_state_e state_q [N_ENTRIES];
  hpdcache_wbuf_sched_state_e state_d [N_ENTRIES];
  logic [TIMECNT_WIDTH-1:0]   cnt_q   [N_ENTRIES];
  logic [TIMECNT_WIDTH-1:0]   cnt_d   [N_ENTRIES];
  logic [N_ENTRIES-1:0]       free_vec, pend_vec;
  logic                       send_hs;

  always_comb begin
    free_vec = '0;
    pend_vec = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      free_vec[i] = (state_q[i] == FREE);
      pend_vec[i] = (state_q[i] == PEND);
    end
  end

  // Lowest-index free entry.
  always_comb begin
    alloc_idx_o = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx_o = IDX_W'(i);
    end
  end

  assign full_o      = ~|free_vec;
  assign empty_o     = &free_vec;
  assign alloc_gnt_o = alloc_req_i & ~full_o;
  assign send_hs     = send_valid_o & send_ready_i;

  hpdcache_rrarb #(
    .N (N_ENTRIES)
  ) i_send_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (pend_vec),
    .ready_i (send_ready_i),
    .valid_o (send_valid_o),
    .idx_o   (send_idx_o)
  );

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        FREE: begin
          if (alloc_gnt_o && (alloc_idx_o == IDX_W'(i))) begin
            state_d[i] = OPEN;
            cnt_d[i]   = '0;
          end
        end
        OPEN: begin
          // Forced close beats a write-triggered counter restart.
          if ((close_i && (close_idx_i == IDX_W'(i))) || flush_all_i) begin
            state_d[i] = PEND;
          end else if (write_i && (write_idx_i == IDX_W'(i)) && cfg_reset_timecnt_on_write_i) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] >= cfg_threshold_i) begin
            state_d[i] = PEND;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        PEND: begin
          if (send_hs && (send_idx_o == IDX_W'(i))) state_d[i] = SENT;
        end
        SENT: begin
          if (ack_i && (ack_idx_i == IDX_W'(i))) state_d[i] = FREE;
        end
        default: state_d[i] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= FREE;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (write_i) assert (state_q[write_idx_i] == OPEN) else $error("wbuf sched: write to non-open entry");
      if (close_i) assert (state_q[close_idx_i] == OPEN) else $error("wbuf sched: close of non-open entry");
      if (ack_i)   assert (state_q[ack_idx_i] == SENT)   else $error("wbuf sched: ack of non-sent entry");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_wbuf_flush_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hpdcache_wbuf_flush_sched : self-checking bench for the scheduler |
// | Revision                     : 1.0                                   |
// +----------------------------------------------------------------------+
module tb_hpdcache_wbuf_flush_sched;

  localparam int N  = 16;
  localparam int TW = 4;
  localparam int IW = 4;

  localparam int M_FREE = 0;
  localparam int M_OPEN = 1;
  localparam int M_PEND = 2;
  localparam int M_SENT = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [TW-1:0] cfg_threshold_i;
  logic          cfg_reset_timecnt_on_write_i;
  logic          alloc_req_i;
  logic          alloc_gnt_o;
  logic [IW-1:0] alloc_idx_o;
  logic          write_i;
  logic [IW-1:0] write_idx_i;
  logic          close_i;
  logic [IW-1:0] close_idx_i;
  logic          flush_all_i;
  logic          send_valid_o;
  logic [IW-1:0] send_idx_o;
  logic          send_ready_i;
  logic          ack_i;
  logic [IW-1:0] ack_idx_i;
  logic          empty_o;
  logic          full_o;

  always #5 clk_i = ~clk_i;

  hpdcache_wbuf_flush_sched #(
    .N_ENTRIES     (N),
    .TIMECNT_WIDTH (TW)
  ) dut (
    .clk_i                        (clk_i),
    .rst_ni                       (rst_ni),
    .cfg_threshold_i              (cfg_threshold_i),
    .cfg_reset_timecnt_on_write_i (cfg_reset_timecnt_on_write_i),
    .alloc_req_i                  (alloc_req_i),
    .alloc_gnt_o                  (alloc_gnt_o),
    .alloc_idx_o                  (alloc_idx_o),
    .write_i                      (write_i),
    .write_idx_i                  (write_idx_i),
    .close_i                      (close_i),
    .close_idx_i                  (close_idx_i),
    .flush_all_i                  (flush_all_i),
    .send_valid_o                 (send_valid_o),
    .send_idx_o                   (send_idx_o),
    .send_ready_i                 (send_ready_i),
    .ack_i                        (ack_i),
    .ack_idx_i                    (ack_idx_i),
    .empty_o                      (empty_o),
    .full_o                       (full_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: entry lifecycle as plain integers.
  int mst  [N];
  int mage [N];
  int mptr;
  int mheld;
  int e_gnt, e_aidx, e_vld, e_sidx, e_empty, e_full;

  function automatic void mreset();
    for (int i = 0; i < N; i++) begin
      mst[i]  = M_FREE;
      mage[i] = 0;
    end
    mptr  = 0;
    mheld = -1;
  endfunction

  function automatic void mpredict();
    int nfree;
    nfree  = 0;
    e_aidx = 0;
    e_vld  = 0;
    e_sidx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mst[i] == M_FREE) begin
        nfree++;
        e_aidx = i;
      end
    end
    e_empty = (nfree == N) ? 1 : 0;
    e_full  = (nfree == 0) ? 1 : 0;
    e_gnt   = (alloc_req_i && e_full == 0) ? 1 : 0;
    if (mheld >= 0) begin
      e_vld  = 1;
      e_sidx = mheld;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (e_vld == 0 && mst[(mptr + k) % N] == M_PEND) begin
          e_vld  = 1;
          e_sidx = (mptr + k) % N;
        end
      end
    end
  endfunction

  function automatic void madvance();
    int nst  [N];
    int nage [N];
    bit hs;
    hs = (e_vld != 0) && send_ready_i;
    for (int i = 0; i < N; i++) begin
      nst[i]  = mst[i];
      nage[i] = mage[i];
      case (mst[i])
        M_FREE: if (e_gnt != 0 && e_aidx == i) begin nst[i] = M_OPEN; nage[i] = 0; end
        M_OPEN: begin
          if ((close_i && int'(close_idx_i) == i) || flush_all_i) nst[i] = M_PEND;
          else if (write_i && int'(write_idx_i) == i && cfg_reset_timecnt_on_write_i) nage[i] = 0;
          else if (mage[i] >= int'(cfg_threshold_i)) nst[i] = M_PEND;
          else nage[i] = (mage[i] == (1 << TW) - 1) ? mage[i] : mage[i] + 1;
        end
        M_PEND: if (hs && e_sidx == i) nst[i] = M_SENT;
        default: if (ack_i && int'(ack_idx_i) == i) nst[i] = M_FREE;
      endcase
    end
    mheld = (e_vld != 0 && !send_ready_i) ? e_sidx : -1;
    if (hs) mptr = (e_sidx + 1) % N;
    mst  = nst;
    mage = nage;
  endfunction

  // Mid-cycle: compare every output against the model.
  task automatic eval(input string tag);
    #4;
    if (!rst_ni) mreset();
    mpredict();
    check({tag, ".gnt"},   alloc_gnt_o,  e_gnt);
    check({tag, ".empty"}, empty_o,      e_empty);
    check({tag, ".full"},  full_o,       e_full);
    check({tag, ".valid"}, send_valid_o, e_vld);
    if (e_full == 0) check({tag, ".aidx"}, alloc_idx_o, e_aidx);
    if (e_vld != 0)  check({tag, ".sidx"}, send_idx_o,  e_sidx);
  endtask

  task automatic adv();
    if (!rst_ni) mreset();
    else madvance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    alloc_req_i  = 1'b0;
    write_i      = 1'b0;
    write_idx_i  = '0;
    close_i      = 1'b0;
    close_idx_i  = '0;
    flush_all_i  = 1'b0;
    send_ready_i = 1'b0;
    ack_i        = 1'b0;
    ack_idx_i    = '0;
  endtask

  task automatic do_reset(input int thr, input bit rb);
    idle();
    rst_ni                       = 1'b0;
    cfg_threshold_i              = TW'(thr);
    cfg_reset_timecnt_on_write_i = rb;
    eval("rst");
    check("rst.empty", empty_o, 1);
    check("rst.full",  full_o, 0);
    check("rst.valid", send_valid_o, 0);
    check("rst.gnt",   alloc_gnt_o, 0);
    check("rst.aidx",  alloc_idx_o, 0);
    check("rst.sidx",  send_idx_o, 0);
    adv();
    rst_ni = 1'b1;
  endtask

  typedef struct {
    bit areq; bit cls; int cidx; bit rdy; bit ack; int akidx;
    int gnt; int aidx; int vld; int sidx; int empty; int full;
  } vec_t;

  function automatic vec_t mk(bit areq, bit cls, int cidx, bit rdy, bit ack, int akidx,
                              int gnt, int aidx, int vld, int sidx, int empty, int full);
    vec_t v;
    v.areq = areq; v.cls = cls; v.cidx = cidx; v.rdy = rdy; v.ack = ack; v.akidx = akidx;
    v.gnt = gnt; v.aidx = aidx; v.vld = vld; v.sidx = sidx; v.empty = empty; v.full = full;
    return v;
  endfunction

  vec_t tbl [12];
  int   q [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni                       = 1'b0;
    cfg_threshold_i              = '0;
    cfg_reset_timecnt_on_write_i = 1'b0;
    idle();
    mreset();
    @(posedge clk_i);
    #1;

    // Directed vectors from reset, threshold 15 so nothing ages out.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,  0, 3, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0,  0, 3, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0,  0, 3, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1, 0,  0, 3, 1, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0,  0, 3, 1, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 1,  0, 3, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    do_reset(15, 0);
    for (int r = 0; r < 12; r++) begin
      idle();
      alloc_req_i  = tbl[r].areq;
      close_i      = tbl[r].cls;
      close_idx_i  = IW'(tbl[r].cidx);
      send_ready_i = tbl[r].rdy;
      ack_i        = tbl[r].ack;
      ack_idx_i    = IW'(tbl[r].akidx);
      eval($sformatf("tbl%0d", r));
      check($sformatf("tbl%0d.gnt", r),   alloc_gnt_o,  tbl[r].gnt);
      check($sformatf("tbl%0d.aidx", r),  alloc_idx_o,  tbl[r].aidx);
      check($sformatf("tbl%0d.valid", r), send_valid_o, tbl[r].vld);
      check($sformatf("tbl%0d.empty", r), empty_o,      tbl[r].empty);
      check($sformatf("tbl%0d.full", r),  full_o,       tbl[r].full);
      if (tbl[r].vld != 0) check($sformatf("tbl%0d.sidx", r), send_idx_o, tbl[r].sidx);
      adv();
    end

    // Ageing: alloc at t, offered at t+5, sent, acked at t+10, empty at t+11.
    do_reset(3, 0);
    alloc_req_i = 1'b1;
    eval("age"); check("age.gnt", alloc_gnt_o, 1); check("age.aidx", alloc_idx_o, 0);
    adv(); idle();
    for (int k = 1; k <= 4; k++) begin eval("age"); check("age.wait", send_valid_o, 0); adv(); end
    eval("age"); check("age.valid", send_valid_o, 1); check("age.sidx", send_idx_o, 0);
    send_ready_i = 1'b1;
    adv(); idle();
    for (int k = 6; k <= 9; k++) begin eval("age"); adv(); end
    ack_i = 1'b1; ack_idx_i = 4'd0;
    eval("age"); check("age.ackcyc_empty", empty_o, 0);
    adv(); idle();
    eval("age"); check("age.empty", empty_o, 1);
    adv();

    // Write restarts the counter: write at w leaves it at 0 in w+1, offered at w+thr+2.
    do_reset(3, 1);
    alloc_req_i = 1'b1; eval("wr"); adv(); idle();
    eval("wr"); adv(); eval("wr"); adv();
    write_i = 1'b1; write_idx_i = 4'd0; eval("wr"); adv(); idle();
    for (int k = 1; k <= 4; k++) begin eval("wr"); check("wrst.wait", send_valid_o, 0); adv(); end
    eval("wr"); check("wrst.pend", send_valid_o, 1); adv();

    // Same sequence with the restart disabled: offered at alloc+5.
    do_reset(3, 0);
    alloc_req_i = 1'b1; eval("wn"); adv(); idle();
    eval("wn"); adv(); eval("wn"); adv();
    write_i = 1'b1; write_idx_i = 4'd0; eval("wn"); adv(); idle();
    eval("wn"); check("wnorst.wait", send_valid_o, 0); adv();
    eval("wn"); check("wnorst.pend", send_valid_o, 1); adv();

    // Fill all entries, refuse a 17th, recycle entry 7.
    do_reset(15, 0);
    for (int k = 0; k < N; k++) begin
      alloc_req_i = 1'b1;
      eval("fill"); check("fill.gnt", alloc_gnt_o, 1); check("fill.idx", alloc_idx_o, k);
      adv();
    end
    idle();
    alloc_req_i = 1'b1; close_i = 1'b1; close_idx_i = 4'd7;
    eval("fill"); check("fill.full", full_o, 1); check("fill.gnt17", alloc_gnt_o, 0);
    adv();
    for (int k = 0; k < 40; k++) begin
      if (mst[7] == M_SENT) break;
      idle(); send_ready_i = 1'b1;
      eval("fill"); adv();
    end
    if (mst[7] != M_SENT) begin
      n_cmp++; n_bad++;
      $display("FAIL fill.sent7: entry 7 never sent within bound");
    end
    idle();
    ack_i = 1'b1; ack_idx_i = 4'd7; alloc_req_i = 1'b1;
    eval("fill"); check("fill.ackcyc_gnt", alloc_gnt_o, 0);
    adv(); idle();
    alloc_req_i = 1'b1;
    eval("fill"); check("fill.regnt", alloc_gnt_o, 1); check("fill.reidx", alloc_idx_o, 7);
    adv(); idle();

    // Round robin with backpressure: 2, 5, 9 pending; offer held at 2.
    do_reset(15, 0);
    for (int k = 0; k < 10; k++) begin alloc_req_i = 1'b1; eval("rr"); adv(); end
    idle(); close_i = 1'b1; close_idx_i = 4'd2; eval("rr"); adv();
    idle(); close_i = 1'b1; close_idx_i = 4'd5;
    eval("rr"); check("rr.hold", send_idx_o, 2); adv();
    idle(); close_i = 1'b1; close_idx_i = 4'd9;
    eval("rr"); check("rr.hold", send_idx_o, 2); adv();
    idle();
    for (int k = 0; k < 2; k++) begin eval("rr"); check("rr.hold", send_idx_o, 2); adv(); end
    send_ready_i = 1'b1;
    eval("rr"); check("rr.first", send_idx_o, 2); adv();
    eval("rr"); check("rr.second", send_idx_o, 5); adv();
    eval("rr"); check("rr.third", send_idx_o, 9); adv();
    idle();

    // Flush beats a same-cycle counter-restart write on entry 3.
    do_reset(15, 1);
    for (int k = 0; k < 4; k++) begin alloc_req_i = 1'b1; eval("fl"); adv(); end
    idle(); flush_all_i = 1'b1; write_i = 1'b1; write_idx_i = 4'd3;
    eval("fl"); check("flush.before", send_valid_o, 0); adv();
    idle(); send_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eval("fl"); check("flush.valid", send_valid_o, 1); check("flush.idx", send_idx_o, k); adv();
    end
    idle();

    // Randomised legal traffic against the model.
    do_reset(5, 0);
    for (int c = 0; c < 3000; c++) begin
      idle();
      if (c % 250 == 0) begin
        cfg_threshold_i              = TW'($urandom_range(0, (1 << TW) - 1));
        cfg_reset_timecnt_on_write_i = 1'($urandom_range(0, 1));
      end
      rst_ni = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if (rst_ni) begin
        alloc_req_i  = 1'($urandom_range(0, 1));
        send_ready_i = ($urandom_range(0, 2) != 0);
        flush_all_i  = ($urandom_range(0, 49) == 0);
        q.delete();
        for (int i = 0; i < N; i++) if (mst[i] == M_OPEN) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
          write_i = 1'b1; write_idx_i = IW'(q[$urandom_range(0, q.size() - 1)]);
        end
        if (q.size() > 0 && $urandom_range(0, 3) == 0) begin
          close_i = 1'b1; close_idx_i = IW'(q[$urandom_range(0, q.size() - 1)]);
        end
        q.delete();
        for (int i = 0; i < N; i++) if (mst[i] == M_SENT) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          ack_i = 1'b1; ack_idx_i = IW'(q[$urandom_range(0, q.size() - 1)]);
        end
      end
      eval("rnd");
      adv();
    end
    rst_ni = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
